// File: rtl/condlogic_mc_pkg.sv
// Shared definitions for the multi-bank condition logic: condition codes
// and NZCV bit positions within a 4-bit flags word.
package condlogic_mc_pkg;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  localparam int FN = 3;
  localparam int FZ = 2;
  localparam int FC = 1;
  localparam int FV = 0;

endpackage

// File: rtl/condlogic_mc_cond_eval.sv
// Pure combinational condition decode of a 4-bit condition field against NZCV.
module cond_eval
  import condlogic_mc_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v, ge;

  assign n  = Flags[FN];
  assign z  = Flags[FZ];
  assign c  = Flags[FC];
  assign v  = Flags[FV];
  assign ge = (n == v);

  // Full 16-way decode; NV resolves to 0 so the result is never X.
  always_comb begin
    CondEx = 1'b0;
    case (cond_e'(Cond))
      CC_EQ: CondEx = z;
      CC_NE: CondEx = ~z;
      CC_CS: CondEx = c;
      CC_CC: CondEx = ~c;
      CC_MI: CondEx = n;
      CC_PL: CondEx = ~n;
      CC_VS: CondEx = v;
      CC_VC: CondEx = ~v;
      CC_HI: CondEx = c & ~z;
      CC_LS: CondEx = ~(c & ~z);
      CC_GE: CondEx = ge;
      CC_LT: CondEx = ~ge;
      CC_GT: CondEx = ~z & ge;
      CC_LE: CondEx = ~(~z & ge);
      CC_AL: CondEx = 1'b1;
      CC_NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/condlogic_mc.sv
// Condition logic with NBANK selectable NZCV flag banks and one saved-flags
// register. All state lives here; decode is delegated to cond_eval.
module condlogic_mc
  import condlogic_mc_pkg::*;
#(
  parameter int NBANK = 1,
  parameter int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    Cond,
  input  logic [3:0]    ALUFlags,
  input  logic [1:0]    FlagW,
  input  logic [BW-1:0] BankSel,
  input  logic          CondLatch,
  input  logic          PCS,
  input  logic          NextPC,
  input  logic          RegW,
  input  logic          MemW,
  input  logic          FlagSave,
  input  logic          FlagRestore,
  output logic          PCWrite,
  output logic          RegWrite,
  output logic          MemWrite,
  output logic          CondEx,
  output logic          CondExDelayed,
  output logic [3:0]    Flags
);

  // One extra bit so NBANK itself is representable (e.g. NBANK=4, BW=2).
  localparam logic [BW:0] NB = (BW+1)'(NBANK);

  logic [NBANK-1:0][3:0] bank_q;
  logic [3:0]            saved_q;
  logic                  ced_q;
  logic                  sel_ok;

  // Out-of-range selects (possible when NBANK is not a power of two) read as
  // zero and block every bank write.
  assign sel_ok = ({1'b0, BankSel} < NB);

  // Active-bank read mux.
  always_comb begin
    Flags = 4'b0000;
    for (int b = 0; b < NBANK; b++)
      if (sel_ok && (BankSel == BW'(b))) Flags = bank_q[b];
  end

  cond_eval u_cond_eval (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (CondEx)
  );

  // Bank update: restore beats FlagW on the selected bank; N,Z and C,V halves
  // are written independently when the instruction's condition passes.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q <= '0;
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        if (sel_ok && (BankSel == BW'(b))) begin
          if (FlagRestore) begin
            bank_q[b] <= saved_q;
          end else begin
            if (FlagW[1] && CondEx) bank_q[b][FN:FZ] <= ALUFlags[FN:FZ];
            if (FlagW[0] && CondEx) bank_q[b][FC:FV] <= ALUFlags[FC:FV];
          end
        end
      end
    end
  end

  // Saved register takes the pre-edge active flags, so save+restore swaps.
  always_ff @(posedge clk) begin
    if (reset)         saved_q <= 4'b0000;
    else if (FlagSave) saved_q <= Flags;
  end

  // Delayed condition, captured only when requested.
  always_ff @(posedge clk) begin
    if (reset)          ced_q <= 1'b0;
    else if (CondLatch) ced_q <= CondEx;
  end

  assign CondExDelayed = ced_q;
  assign PCWrite       = (PCS & CondEx) | NextPC;
  assign RegWrite      = RegW & ced_q;
  assign MemWrite      = MemW & ced_q;

endmodule

// File: tb/tb_condlogic_mc.sv
// Randomized bench for condlogic_mc: two instances (NBANK=2, NBANK=3) share
// stimulus and are checked against an architectural flag-bank model.
module tb_condlogic_mc;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cond, aluf;
  logic [1:0] flagw, bs;
  logic       clatch, pcs, nextpc, regw, memw, fsave, frest;

  logic       pcw2, rw2, mw2, cex2, ced2;
  logic [3:0] fl2;
  logic       pcw3, rw3, mw3, cex3, ced3;
  logic [3:0] fl3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  condlogic_mc #(.NBANK(2)) dut2 (
    .clk(clk), .reset(reset), .Cond(cond), .ALUFlags(aluf), .FlagW(flagw),
    .BankSel(bs[0]), .CondLatch(clatch), .PCS(pcs), .NextPC(nextpc),
    .RegW(regw), .MemW(memw), .FlagSave(fsave), .FlagRestore(frest),
    .PCWrite(pcw2), .RegWrite(rw2), .MemWrite(mw2), .CondEx(cex2),
    .CondExDelayed(ced2), .Flags(fl2)
  );

  condlogic_mc #(.NBANK(3)) dut3 (
    .clk(clk), .reset(reset), .Cond(cond), .ALUFlags(aluf), .FlagW(flagw),
    .BankSel(bs), .CondLatch(clatch), .PCS(pcs), .NextPC(nextpc),
    .RegW(regw), .MemW(memw), .FlagSave(fsave), .FlagRestore(frest),
    .PCWrite(pcw3), .RegWrite(rw3), .MemWrite(mw3), .CondEx(cex3),
    .CondExDelayed(ced3), .Flags(fl3)
  );

  // Model state: index 0 mirrors the NBANK=2 instance, index 1 the NBANK=3 one.
  logic [3:0] mbank [2][4];
  logic [3:0] msave [2];
  logic       mced  [2];
  int         nbk   [2] = '{2, 3};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ARM-style: condition pairs share a base test, the low bit inverts it.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c[3:1] == 3'd7) return (c == 4'hE);
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      default: r = !z && (n == v);
    endcase
    return r ^ c[0];
  endfunction

  function automatic int msel(input int i);
    return (i == 0) ? int'(bs[0]) : int'(bs);
  endfunction

  function automatic logic [3:0] mflags(input int i);
    return (msel(i) < nbk[i]) ? mbank[i][msel(i)] : 4'b0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < 4; b++) mbank[i][b] = 4'b0;
      msave[i] = 4'b0;
      mced[i]  = 1'b0;
    end
  endtask

  // Compare every output of both instances against the model.
  task automatic settle();
    logic e;
    #1;
    for (int i = 0; i < 2; i++) begin
      e = cond_ok(cond, mflags(i));
      if (i == 0) begin
        chk("flags2", 8'(fl2), 8'(mflags(0)));
        chk("condex2", 8'(cex2), 8'(e));
        chk("ced2", 8'(ced2), 8'(mced[0]));
        chk("pcw2", 8'(pcw2), 8'((pcs & e) | nextpc));
        chk("rw2", 8'(rw2), 8'(regw & mced[0]));
        chk("mw2", 8'(mw2), 8'(memw & mced[0]));
      end else begin
        chk("flags3", 8'(fl3), 8'(mflags(1)));
        chk("condex3", 8'(cex3), 8'(e));
        chk("ced3", 8'(ced3), 8'(mced[1]));
        chk("pcw3", 8'(pcw3), 8'((pcs & e) | nextpc));
        chk("rw3", 8'(rw3), 8'(regw & mced[1]));
        chk("mw3", 8'(mw3), 8'(memw & mced[1]));
      end
    end
  endtask

  // Advance one edge, updating the model from pre-edge values.
  task automatic tick();
    logic [3:0] f, nf;
    logic e;
    int s;
    @(posedge clk);
    if (reset) model_reset();
    else begin
      for (int i = 0; i < 2; i++) begin
        s = msel(i);
        f = mflags(i);
        e = cond_ok(cond, f);
        if (s < nbk[i]) begin
          nf = f;
          if (frest) nf = msave[i];
          else begin
            if (flagw[1] && e) nf[3:2] = aluf[3:2];
            if (flagw[0] && e) nf[1:0] = aluf[1:0];
          end
          mbank[i][s] = nf;
        end
        if (fsave)  msave[i] = f;
        if (clatch) mced[i]  = e;
      end
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; cond = 4'hE; aluf = 0; flagw = 0; bs = 0; clatch = 0;
    pcs = 0; nextpc = 0; regw = 0; memw = 0; fsave = 0; frest = 0;
  endtask

  initial begin
    model_reset();
    idle();
    reset = 1; flagw = 2'b11; aluf = 4'hF;
    settle(); tick();
    reset = 0; flagw = 0; regw = 1; memw = 1; pcs = 1; cond = 4'hF;
    settle();
    chk("rst_flags", 8'(fl3), 8'h0);
    chk("rst_ced", 8'(ced3), 8'h0);
    chk("rst_regwrite", 8'(rw3), 8'h0);
    chk("rst_pcwrite_nv", 8'(pcw3), 8'h0);

    // Unconditional write then EQ passes.
    idle(); cond = 4'hE; flagw = 2'b11; aluf = 4'b0100;
    settle(); tick();
    idle(); cond = 4'h0;
    settle();
    chk("al_write", 8'(fl3), 8'h4);
    chk("eq_after", 8'(cex3), 8'h1);
    tick();

    // RegWrite/MemWrite follow the latched condition only.
    idle(); cond = 4'h1; clatch = 1;
    settle(); tick();
    idle(); regw = 1; memw = 1; cond = 4'hE;
    settle();
    chk("rw_blocked", 8'(rw3), 8'h0);
    chk("mw_blocked", 8'(mw3), 8'h0);
    tick(); settle();
    chk("rw_still", 8'(rw3), 8'h0);
    clatch = 1; tick(); clatch = 0;
    settle();
    chk("rw_relatch", 8'(rw3), 8'h1);

    // Failing condition blocks flag writes.
    idle(); reset = 1; settle(); tick();
    idle(); cond = 4'h0; flagw = 2'b11; aluf = 4'hF;
    settle();
    chk("eq_fail", 8'(cex3), 8'h0);
    tick(); idle(); settle();
    chk("no_write", 8'(fl3), 8'h0);

    // Independent halves.
    idle(); flagw = 2'b10; aluf = 4'hF; settle(); tick();
    idle(); settle();
    chk("nz_only", 8'(fl3), 8'hC);
    flagw = 2'b01; aluf = 4'hF; settle(); tick();
    idle(); settle();
    chk("cv_also", 8'(fl3), 8'hF);

    // Bank select and out-of-range handling.
    idle(); reset = 1; settle(); tick();
    idle(); flagw = 2'b11; aluf = 4'b1010; settle(); tick();
    idle(); bs = 2'd1; settle();
    chk("bank1_empty", 8'(fl2), 8'h0);
    bs = 2'd3; flagw = 2'b11; aluf = 4'hF; frest = 1'b0;
    settle();
    chk("oor_flags3", 8'(fl3), 8'h0);
    tick();
    idle(); bs = 2'd3; frest = 1; settle(); tick();
    idle(); bs = 2'd3; settle();
    chk("oor_nowrite", 8'(fl3), 8'h0);
    chk("bank1_wrapped", 8'(fl2), 8'h0);
    bs = 2'd0; settle();
    chk("bank0_kept", 8'(fl3), 8'hA);

    // Save/restore swap, restore priority, reset override.
    idle(); reset = 1; settle(); tick();
    idle(); flagw = 2'b11; aluf = 4'b1001; settle(); tick();
    idle(); fsave = 1; settle(); tick();
    idle(); flagw = 2'b11; aluf = 4'b0110; settle(); tick();
    idle(); fsave = 1; frest = 1; flagw = 2'b11; aluf = 4'hF; settle(); tick();
    idle(); settle();
    chk("swap_bank", 8'(fl3), 8'h9);
    frest = 1; settle(); tick();
    idle(); settle();
    chk("swap_saved", 8'(fl3), 8'h6);
    reset = 1; flagw = 2'b11; aluf = 4'hF; clatch = 1; settle(); tick();
    idle(); fsave = 0; frest = 1; settle(); tick();
    idle(); settle();
    chk("reset_all", 8'(fl3), 8'h0);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      reset  = ($urandom_range(0, 63) == 0);
      cond   = 4'($urandom);
      aluf   = 4'($urandom);
      flagw  = 2'($urandom);
      bs     = 2'($urandom);
      clatch = 1'($urandom);
      pcs    = 1'($urandom);
      nextpc = ($urandom_range(0, 3) == 0);
      regw   = 1'($urandom);
      memw   = 1'($urandom);
      fsave  = ($urandom_range(0, 5) == 0);
      frest  = ($urandom_range(0, 5) == 0);
      settle(); tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/condlogic_mc.md
CONDLOGIC_MC -- requirements
Module: condlogic_mc

Interface
REQ-001 SHALL have parameter NBANK, default 1, number of independent NZCV flag banks (legal 1..4).
REQ-002 SHALL have derived parameter BW, default 1, BankSel width = max(1, clog2(NBANK)).
REQ-003 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Cond  input  4  condition field of the current instruction.
REQ-006 SHALL have port ALUFlags  input  4  ALU result flags {N,Z,C,V} (bit3..bit0).
REQ-007 SHALL have port FlagW  input  2  flag write request: bit1 = N,Z; bit0 = C,V.
REQ-008 SHALL have port BankSel  input  BW  selects the active flag bank for read and write.
REQ-009 SHALL have port CondLatch  input  1  capture CondEx into CondExDelayed this cycle.
REQ-010 SHALL have port PCS, NextPC, RegW, MemW  input  1 each  unqualified write requests from control.
REQ-011 SHALL have port FlagSave, FlagRestore  input  1 each  copy active bank to/from the saved-flags register.
REQ-012 SHALL have port PCWrite, RegWrite, MemWrite  output  1 each  condition-qualified write enables.
REQ-013 SHALL have port CondEx  output  1  combinational condition result.
REQ-014 SHALL have port CondExDelayed  output  1  registered condition result.
REQ-015 SHALL have port Flags  output  4  active bank flags {N,Z,C,V}.

Function
REQ-016 CondEx SHALL decode Cond against Flags: 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V; 8 HI C&~Z; 9 LS ~(C&~Z); A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE ~(~Z&(N==V)); E AL 1; F NV 0 (never X).
REQ-017 CondExDelayed SHALL load CondEx on the edge where CondLatch=1 and hold otherwise.
REQ-018 Active bank N,Z SHALL load ALUFlags[3:2] at the edge when FlagW[1]&CondEx; C,V SHALL load ALUFlags[1:0] when FlagW[0]&CondEx; each half independent.
REQ-019 Flag updates SHALL be visible on Flags, and in CondEx, the cycle after the write edge (1-cycle latency); no bypass.
REQ-020 PCWrite SHALL equal (PCS & CondEx) | NextPC, combinational.
REQ-021 RegWrite SHALL equal RegW & CondExDelayed; MemWrite SHALL equal MemW & CondExDelayed.
REQ-022 FlagSave SHALL copy the active bank into the saved register at the edge.
REQ-023 FlagRestore SHALL copy the saved register into the active bank, regardless of CondEx.
REQ-024 FlagRestore with FlagW on the same edge: restore SHALL win for all four flags.
REQ-025 FlagSave with FlagRestore on the same edge: bank and saved register SHALL swap (both use pre-edge values).
REQ-026 FlagSave with FlagW on the same edge: saved register SHALL receive pre-edge bank flags.
REQ-027 BankSel >= NBANK: Flags SHALL read 4'b0000; all bank writes, including restore, SHALL be ignored; FlagSave SHALL store 4'b0000.
REQ-028 Non-selected banks SHALL hold their values.

Reset
REQ-029 With reset=1 at an edge, all banks, the saved register and CondExDelayed SHALL become 0; reset SHALL override every same-cycle write.
REQ-030 After reset, outputs SHALL be: Flags=0, CondExDelayed=0, RegWrite=MemWrite=0; PCWrite follows REQ-020.

Structure
REQ-031 The shared package SHALL hold the 4-bit condition-code enum (EQ..NV) and the flag bit indices N=3, Z=2, C=1, V=0.
REQ-032 Condition decode SHALL be the combinational sub-module cond_eval (Cond, Flags -> CondEx); all state SHALL live in condlogic_mc.

Verification
REQ-033 Reset, then Cond=E, FlagW=11, ALUFlags=0100 -> next cycle Flags=0100; Cond=0 gives CondEx=1.
REQ-034 Flags=0000, Cond=0 (EQ), FlagW=11, ALUFlags=1111 -> CondEx=0, Flags stay 0000.
REQ-035 Flags=0000, FlagW=10, ALUFlags=1111, Cond=E -> Flags=1100; then FlagW=01 -> Flags=1111.
REQ-036 CondLatch=1 with CondEx=0, then RegW=MemW=1 while Cond changes to E -> RegWrite=MemWrite=0 until the next CondLatch.
REQ-037 NBANK=2: write 1010 to bank 0, then BankSel=1 -> Flags=0000; BankSel=3 (BW=1 so 1) is in range; NBANK=3, BankSel=3 -> Flags=0000, writes ignored.
REQ-038 Bank=0110, saved=1001, FlagSave=FlagRestore=1, FlagW=11 -> bank=1001, saved=0110; reset asserted with FlagW=11 -> all 0.
